vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_controller.sv | 128 ++++++++++++
 tb/tb_vend_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending machine controller.
// Coin values are in cents.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE
    } state_t;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

endpackage

// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE,
// and pays change or refunds as a train of nickel pulses.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE    = 35,
    parameter int CREDIT_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dimeDetected,
    input  logic                nickelDetected,
    input  logic                quarterDetected,
    input  logic                cancel,
    output logic                vend,
    output logic                changeNickel,
    output logic                coinReject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] LP_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] LP_NICKEL  = CREDIT_W'(NICKEL_C);
    localparam logic [CREDIT_W-1:0] LP_DIME    = CREDIT_W'(DIME_C);
    localparam logic [CREDIT_W-1:0] LP_QUARTER = CREDIT_W'(QUARTER_C);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_phase;
    logic                w_phase_nxt;
    logic                r_vend;
    logic                r_change;
    logic                r_reject;
    logic                r_busy;
    logic                w_reject_nxt;
    logic [1:0]          w_coin_cnt;
    logic                w_coin_any;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;

    assign w_coin_cnt = {1'b0, nickelDetected}
                      + {1'b0, dimeDetected}
                      + {1'b0, quarterDetected};
    assign w_coin_any = (w_coin_cnt != 2'd0);

    // Only meaningful when exactly one coin is present.
    assign w_coin_val = (nickelDetected  ? LP_NICKEL  : '0)
                      + (dimeDetected    ? LP_DIME    : '0)
                      + (quarterDetected ? LP_QUARTER : '0);
    assign w_sum      = r_credit + w_coin_val;

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_phase_nxt  = r_phase;
        w_reject_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_coin_cnt > 2'd1) begin
                    w_reject_nxt = 1'b1;
                end else if (w_coin_any) begin
                    w_credit_nxt = w_sum;
                    if (w_sum >= LP_PRICE) begin
                        w_state_nxt = VEND;
                    end
                end else if (cancel && (r_credit != '0)) begin
                    w_state_nxt = CHANGE;
                    w_phase_nxt = 1'b1;
                end
            end
            VEND: begin
                w_reject_nxt = w_coin_any;
                w_credit_nxt = r_credit - LP_PRICE;
                if (r_credit != LP_PRICE) begin
                    w_state_nxt = CHANGE;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CHANGE: begin
                w_reject_nxt = w_coin_any;
                if (r_phase) begin
                    w_credit_nxt = r_credit - LP_NICKEL;
                    w_phase_nxt  = 1'b0;
                    // Last nickel goes straight back to IDLE, no gap.
                    if (r_credit == LP_NICKEL) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_phase_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_phase  <= 1'b0;
            r_vend   <= 1'b0;
            r_change <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_phase  <= w_phase_nxt;
            r_vend   <= (w_state_nxt == VEND);
            r_change <= (w_state_nxt == CHANGE) && w_phase_nxt;
            r_reject <= w_reject_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign vend         = r_vend;
    assign changeNickel = r_change;
    assign coinReject   = r_reject;
    assign busy         = r_busy;
    assign credit       = r_credit;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized self-checking bench for vend_controller (PRICE=35).
// Expected traces come from the purchase/refund rules, not the FSM.
module tb_vend_controller;

    localparam int PRICE = 35;
    localparam int CW    = 7;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          dime     = 1'b0;
    logic          nickel   = 1'b0;
    logic          quarter  = 1'b0;
    logic          cancel   = 1'b0;
    logic          vend;
    logic          changeNickel;
    logic          coinReject;
    logic          busy;
    logic [CW-1:0] credit;

    int checks   = 0;
    int failures = 0;
    int coin_q[$];

    always #5 clk = ~clk;

    vend_controller #(
        .PRICE   (PRICE),
        .CREDIT_W(CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dimeDetected   (dime),
        .nickelDetected (nickel),
        .quarterDetected(quarter),
        .cancel         (cancel),
        .vend           (vend),
        .changeNickel   (changeNickel),
        .coinReject     (coinReject),
        .busy           (busy),
        .credit         (credit)
    );

    // Packed view: {vend, changeNickel, coinReject, busy, credit}
    function automatic logic [10:0] pack(input logic v, input logic c,
                                         input logic r, input logic b,
                                         input int cr);
        return {v, c, r, b, 7'(cr)};
    endfunction

    function automatic logic [10:0] obs();
        return {vend, changeNickel, coinReject, busy, credit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        dime    = 1'b0;
        nickel  = 1'b0;
        quarter = 1'b0;
        cancel  = 1'b0;
    endtask

    task automatic drive_coin(input int v);
        nickel  = (v == 5);
        dime    = (v == 10);
        quarter = (v == 25);
    endtask

    function automatic int rand_coin();
        int sel;
        sel = int'($urandom_range(0, 2));
        return (sel == 0) ? 5 : (sel == 1) ? 10 : 25;
    endfunction

    // Expects rem/5 nickel pulses, one every other cycle, then idle.
    task automatic drain(input string tag, input int rem);
        logic [10:0] e;
        int n;
        n = rem / 5;
        for (int k = 0; k < n; k++) begin
            tick();
            clear_in();
            e = pack(0, 1, 0, 1, rem - 5 * k);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s pulse%0d got=%h want=%h", tag, k, obs(), e);
            end
            if (k < n - 1) begin
                tick();
                e = pack(0, 0, 0, 1, rem - 5 * (k + 1));
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL %s gap%0d got=%h want=%h", tag, k, obs(), e);
                end
            end
        end
        tick();
        clear_in();
        e = pack(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL %s idle got=%h want=%h", tag, obs(), e);
        end
    endtask

    // Inserts coin_q one at a time; vends and pays change once PRICE is met.
    task automatic run_buy(input string tag, input bit gaps);
        logic [10:0] e;
        int sum;
        int g;
        sum = 0;
        foreach (coin_q[i]) begin
            drive_coin(coin_q[i]);
            tick();
            clear_in();
            sum += coin_q[i];
            e = (sum >= PRICE) ? pack(1, 0, 0, 1, sum) : pack(0, 0, 0, 0, sum);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s coin%0d got=%h want=%h", tag, i, obs(), e);
            end
            if (gaps && sum < PRICE) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    tick();
                    checks++;
                    if (obs() !== pack(0, 0, 0, 0, sum)) begin
                        failures++;
                        $display("FAIL %s hold got=%h want=%h",
                                 tag, obs(), pack(0, 0, 0, 0, sum));
                    end
                end
            end
        end
        if (sum >= PRICE) drain(tag, sum - PRICE);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_in();
        tick();
        tick();
        checks++;
        if (obs() !== pack(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_hold got=%h want=%h", obs(), pack(0, 0, 0, 0, 0));
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== pack(0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL reset_idle%0d got=%h want=%h",
                         i, obs(), pack(0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_purchase();
        coin_q = '{25, 10};
        run_buy("buy_exact", 1'b0);
        coin_q = '{25, 25};
        run_buy("buy_50", 1'b0);
        coin_q = '{10, 25};
        run_buy("buy_10_25", 1'b0);
        coin_q = '{5, 5, 5, 5, 5, 5, 25};
        run_buy("buy_max", 1'b0);
    endtask

    task automatic test_random_purchase();
        int sum;
        for (int t = 0; t < 20; t++) begin
            coin_q.delete();
            sum = 0;
            while (sum < PRICE) begin
                coin_q.push_back(rand_coin());
                sum += coin_q[$];
            end
            run_buy("buy_rand", 1'b1);
        end
    endtask

    task automatic test_cancel();
        int sum;
        int c;
        int n;
        coin_q = '{10};
        run_buy("cancel_dime", 1'b0);
        cancel = 1'b1;
        drain("cancel_dime", 10);
        cancel = 1'b1;
        tick();
        clear_in();
        checks++;
        if (obs() !== pack(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL cancel_zero got=%h want=%h", obs(), pack(0, 0, 0, 0, 0));
        end
        for (int t = 0; t < 10; t++) begin
            coin_q.delete();
            sum = 0;
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                c = rand_coin();
                if (sum + c < PRICE) begin
                    coin_q.push_back(c);
                    sum += c;
                end
            end
            if (sum == 0) begin
                coin_q.push_back(5);
                sum = 5;
            end
            run_buy("cancel_rand", 1'b1);
            cancel = 1'b1;
            drain("cancel_rand", sum);
        end
    endtask

    task automatic test_reject_idle();
        int combo;
        nickel = 1'b1;
        tick();
        clear_in();
        for (int t = 0; t < 4; t++) begin
            combo = (t == 0) ? 3 : int'($urandom_range(3, 7));
            if (combo == 4) combo = 5;
            nickel  = combo[0];
            dime    = combo[1];
            quarter = combo[2];
            tick();
            clear_in();
            checks++;
            if (obs() !== pack(0, 0, 1, 0, 5)) begin
                failures++;
                $display("FAIL rej_multi got=%h want=%h", obs(), pack(0, 0, 1, 0, 5));
            end
            tick();
            checks++;
            if (obs() !== pack(0, 0, 0, 0, 5)) begin
                failures++;
                $display("FAIL rej_after got=%h want=%h", obs(), pack(0, 0, 0, 0, 5));
            end
        end
        dime   = 1'b1;
        cancel = 1'b1;
        tick();
        clear_in();
        checks++;
        if (obs() !== pack(0, 0, 0, 0, 15)) begin
            failures++;
            $display("FAIL coin_cancel got=%h want=%h", obs(), pack(0, 0, 0, 0, 15));
        end
        cancel = 1'b1;
        drain("coin_cancel", 15);
    endtask

    task automatic test_reject_busy();
        int inj;
        int pulses;
        int rej_seen;
        int cyc;
        for (int t = 0; t < 8; t++) begin
            inj = int'($urandom_range(0, 5));
            drive_coin(25);
            tick();
            drive_coin(25);
            tick();
            clear_in();
            pulses   = 0;
            rej_seen = 0;
            for (cyc = 0; cyc < 30; cyc++) begin
                if (cyc == inj) begin
                    drive_coin(rand_coin());
                    cancel = $urandom_range(0, 1) == 1;
                end
                tick();
                clear_in();
                if (cyc == inj) rej_seen = coinReject ? 1 : 0;
                else if (coinReject) rej_seen = 2;
                if (changeNickel) pulses++;
                if (!busy) break;
            end
            checks++;
            if (rej_seen != 1) begin
                failures++;
                $display("FAIL rej_busy inj=%0d got=%0d want=1", inj, rej_seen);
            end
            checks++;
            if (pulses != 3 || busy !== 1'b0 || credit !== 7'd0) begin
                failures++;
                $display("FAIL rej_busy_change got=%0d/%b/%0d want=3/0/0",
                         pulses, busy, credit);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_coin(25);
        tick();
        drive_coin(25);
        tick();
        clear_in();
        tick();
        tick();
        tick();
        checks++;
        if (obs() !== pack(0, 1, 0, 1, 10)) begin
            failures++;
            $display("FAIL mid_second got=%h want=%h", obs(), pack(0, 1, 0, 1, 10));
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== pack(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL mid_async got=%h want=%h", obs(), pack(0, 0, 0, 0, 0));
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs() !== pack(0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL mid_after%0d got=%h want=%h",
                         i, obs(), pack(0, 0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_random_purchase();
        test_cancel();
        test_reject_idle();
        test_reject_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
